axil_to_axis: RTL and testbench
===============================

Name: axil_to_axis

Overview:
AXI-lite slave that terminates CPU/interconnect register accesses and re-emits them as axi_stream transactions. It is the responder counterpart of the axis-to-axil master bridge.
- Writes become one beat on axis_write: data=WDATA, dest=AWADDR.
- Reads become a request beat on axis_read_request carrying the address. The block then waits for a single data beat on axis_read_response.
- Sits between the AXI-lite interconnect and stream-based register fabrics or remote cores.

Parameters:
DATA_WIDTH, 32, width of WDATA/RDATA and stream data.
ADDR_WIDTH, 32, width of AWADDR/ARADDR and stream dest/request data.
TIMEOUT_CYCLES, 1024, cycles to wait for a read response before erroring; 0 disables the timeout.

Ports:
clock  in  1  single clock; all logic on posedge.
reset  in  1  asynchronous, active-low reset.
axi_in  axi_lite.slave  iface  AXI-lite slave (AW/W/B/AR/R channels).
axis_write  axi_stream.master  iface  write beats; data=write data, dest=write address.
axis_read_request  axi_stream.master  iface  read requests; data=read address.
axis_read_response  axi_stream.slave  iface  read data returned by the far end.

Behaviour:
- Reset: asynchronous on reset low. All FSMs go to idle and all valids/readys are cleared except as listed below.
  - AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - axis_write.valid/data/dest=0, axis_read_request.valid/data=0, axis_read_response.ready=1.
  - Any in-flight transaction is dropped silently.
- All outputs are registered. Read and write paths are fully independent and run concurrently with no arbitration.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_STREAM, W_RESP.
  - W_IDLE, AW and W handshake in the same cycle: latch both, go to W_STREAM.
  - W_IDLE, AW only: latch it, go to W_HAVE_ADDR. W only: latch it, go to W_HAVE_DATA.
  - AWREADY is high only in W_IDLE and W_HAVE_DATA. WREADY is high only in W_IDLE and W_HAVE_ADDR.
  - W_HAVE_ADDR / W_HAVE_DATA: on the missing handshake, go to W_STREAM.
  - W_STREAM: axis_write.valid=1 with data/dest held stable until ready. On valid&ready: drop valid, set BVALID=1, BRESP=OKAY, go to W_RESP.
  - W_RESP: hold BVALID until BREADY. Then BVALID=0, re-raise AWREADY/WREADY, go to W_IDLE.
  - WSTRB is ignored; every write is forwarded as a full word.
  - Latency: AW+W at edge k gives axis_write.valid at k+1. With ready already high, BVALID rises at k+2.
- Read FSM states: R_IDLE, R_REQUEST, R_WAIT, R_RESP.
  - R_IDLE: ARREADY=1. On AR handshake, latch ARADDR, drop ARREADY, go to R_REQUEST.
  - R_REQUEST: axis_read_request.valid=1, data=latched address, held stable until ready. On handshake: drop valid, clear the timeout counter, go to R_WAIT.
  - R_WAIT: axis_read_response.ready=1; counter increments each cycle.
    - On response valid: RDATA=response data, RRESP=OKAY, RVALID=1, go to R_RESP.
    - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no response: RDATA=READ_TIMEOUT_DATA, RRESP=SLVERR, RVALID=1, go to R_RESP.
    - If the response arrives in the same cycle as the timeout, the response wins.
  - R_RESP: hold RVALID/RDATA until RREADY, then go to R_IDLE.
  - Latency: AR at k gives request valid at k+1. A response accepted at m gives RVALID at m+1.
- Stale responses: axis_read_response.ready is also 1 in R_IDLE. Beats arriving there (late responses after a timeout) are accepted and discarded. ready is 0 in R_REQUEST and R_RESP.
- Counter width: clog2(TIMEOUT_CYCLES+1), saturating; it never wraps.

Decomposition:
- Package axil_to_axis_pkg holds:
  - write and read state enums;
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10;
  - READ_TIMEOUT_DATA=32'hDEADBEEF.
- No sub-module. The block is one module with two independent always_ff processes, one per path, plus the counter.

Test Plan:
1. AW=0x43C0_0010 and W=0x1234_5678 in the same cycle, axis_write.ready=1 → one beat with data=0x12345678, dest=0x43C00010 at k+1; BVALID with BRESP=0 at k+2.
2. W=0xA5A5 three cycles before AW=0x20, axis_write.ready held low for 5 cycles → WREADY drops after W; the beat stays stable until ready; exactly one beat and one B response.
3. AR=0x44, response beat data=0xCAFE 4 cycles after the request handshake, RREADY=0 for 3 cycles → RVALID held with RDATA=0xCAFE, RRESP=0 until RREADY.
4. TIMEOUT_CYCLES=16, AR=0x48 with no response → RVALID after 16 wait cycles with RDATA=0xDEADBEEF, RRESP=2. A late beat 0x1111 is accepted and discarded; the next read of 0x4C returns its own data.
5. Concurrent write to 0x10 and read of 0x14 issued in the same cycle → both complete independently with correct B and R results.
6. Reset asserted mid-write in W_STREAM and mid-read in R_WAIT → all valids drop immediately (asynchronously), AW/W/ARREADY=1, and a fresh write completes normally after release.

Source files
------------

// File: rtl/axil_to_axis_pkg.sv
// Shared types and constants for the AXI-lite to AXI-stream responder bridge.
// Holds the write/read FSM state encodings, AXI response codes and the
// data word returned when a read response never arrives.
package axil_to_axis_pkg;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_STREAM,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQUEST,
    R_WAIT,
    R_RESP
  } r_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR   = 2'b10;
  localparam logic [31:0] READ_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/axil_to_axis.sv
// AXI-lite slave that re-emits register accesses as AXI-stream beats.
//   clock / reset             : single clock, asynchronous active-low reset
//   axi_in_*                  : AXI-lite slave (AW, W, B, AR, R channels)
//   axis_write_*              : one beat per write, data=WDATA, dest=AWADDR
//   axis_read_request_*       : one beat per read, data=ARADDR
//   axis_read_response_*      : single data beat answering each request
// Write and read paths are independent FSMs; all outputs are registered.
module axil_to_axis
  import axil_to_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  // AXI-lite slave
  input  logic [ADDR_WIDTH-1:0] axi_in_awaddr,
  input  logic                  axi_in_awvalid,
  output logic                  axi_in_awready,
  input  logic [DATA_WIDTH-1:0] axi_in_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_in_wstrb,
  input  logic                  axi_in_wvalid,
  output logic                  axi_in_wready,
  output logic [1:0]            axi_in_bresp,
  output logic                  axi_in_bvalid,
  input  logic                  axi_in_bready,
  input  logic [ADDR_WIDTH-1:0] axi_in_araddr,
  input  logic                  axi_in_arvalid,
  output logic                  axi_in_arready,
  output logic [DATA_WIDTH-1:0] axi_in_rdata,
  output logic [1:0]            axi_in_rresp,
  output logic                  axi_in_rvalid,
  input  logic                  axi_in_rready,
  // write stream master
  output logic                  axis_write_valid,
  input  logic                  axis_write_ready,
  output logic [DATA_WIDTH-1:0] axis_write_data,
  output logic [ADDR_WIDTH-1:0] axis_write_dest,
  // read request stream master
  output logic                  axis_read_request_valid,
  input  logic                  axis_read_request_ready,
  output logic [ADDR_WIDTH-1:0] axis_read_request_data,
  // read response stream slave
  input  logic                  axis_read_response_valid,
  output logic                  axis_read_response_ready,
  input  logic [DATA_WIDTH-1:0] axis_read_response_data
);

  // Counter is wide enough to hold TIMEOUT_CYCLES and saturates at all-ones.
  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Byte strobes carry no meaning here: every write is a full word.
  logic wstrb_unused;
  assign wstrb_unused = ^axi_in_wstrb;

  // ---------------- write path ----------------
  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] wr_dest_q, wr_dest_d;
  logic                  aw_hs, w_hs;

  assign aw_hs = axi_in_awvalid & awready_q;
  assign w_hs  = axi_in_wvalid & wready_q;

  always_comb begin
    w_state_d  = w_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_valid_d = wr_valid_q;
    wr_data_d  = wr_data_q;
    wr_dest_d  = wr_dest_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          wr_dest_d = axi_in_awaddr;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          wr_data_d = axi_in_wdata;
          wready_d  = 1'b0;
        end
        if (aw_hs && w_hs) begin
          wr_valid_d = 1'b1;
          w_state_d  = W_STREAM;
        end else if (aw_hs) begin
          w_state_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: if (w_hs) begin
        wr_data_d  = axi_in_wdata;
        wready_d   = 1'b0;
        wr_valid_d = 1'b1;
        w_state_d  = W_STREAM;
      end
      W_HAVE_DATA: if (aw_hs) begin
        wr_dest_d  = axi_in_awaddr;
        awready_d  = 1'b0;
        wr_valid_d = 1'b1;
        w_state_d  = W_STREAM;
      end
      W_STREAM: if (axis_write_ready) begin
        wr_valid_d = 1'b0;
        bvalid_d   = 1'b1;
        bresp_d    = AXI_RESP_OKAY;
        w_state_d  = W_RESP;
      end
      W_RESP: if (axi_in_bready) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        wready_d  = 1'b1;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= AXI_RESP_OKAY;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      wr_dest_q  <= '0;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      wr_dest_q  <= wr_dest_d;
    end
  end

  // ---------------- read path ----------------
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0] req_data_q, req_data_d;
  logic                  rsp_ready_q, rsp_ready_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_hs, timed_out;

  assign rsp_hs    = axis_read_response_valid & rsp_ready_q;
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    r_state_d   = r_state_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    req_valid_d = req_valid_q;
    req_data_d  = req_data_q;
    rsp_ready_d = rsp_ready_q;
    cnt_d       = cnt_q;
    case (r_state_q)
      // Beats accepted here are late answers to timed-out reads; dropped.
      R_IDLE: if (axi_in_arvalid && arready_q) begin
        req_data_d  = axi_in_araddr;
        req_valid_d = 1'b1;
        arready_d   = 1'b0;
        rsp_ready_d = 1'b0;
        r_state_d   = R_REQUEST;
      end
      R_REQUEST: if (axis_read_request_ready) begin
        req_valid_d = 1'b0;
        rsp_ready_d = 1'b1;
        cnt_d       = '0;
        r_state_d   = R_WAIT;
      end
      R_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // A response in the timeout cycle takes priority over the error.
        if (rsp_hs) begin
          rdata_d     = axis_read_response_data;
          rresp_d     = AXI_RESP_OKAY;
          rvalid_d    = 1'b1;
          rsp_ready_d = 1'b0;
          r_state_d   = R_RESP;
        end else if (timed_out) begin
          rdata_d     = DATA_WIDTH'(READ_TIMEOUT_DATA);
          rresp_d     = AXI_RESP_SLVERR;
          rvalid_d    = 1'b1;
          rsp_ready_d = 1'b0;
          r_state_d   = R_RESP;
        end
      end
      R_RESP: if (axi_in_rready) begin
        rvalid_d    = 1'b0;
        arready_d   = 1'b1;
        rsp_ready_d = 1'b1;
        r_state_d   = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q   <= R_IDLE;
      arready_q   <= 1'b1;
      rvalid_q    <= 1'b0;
      rresp_q     <= AXI_RESP_OKAY;
      rdata_q     <= '0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      rsp_ready_q <= 1'b1;
    end else begin
      r_state_q   <= r_state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
      rsp_ready_q <= rsp_ready_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign axi_in_awready           = awready_q;
  assign axi_in_wready            = wready_q;
  assign axi_in_bvalid            = bvalid_q;
  assign axi_in_bresp             = bresp_q;
  assign axi_in_arready           = arready_q;
  assign axi_in_rvalid            = rvalid_q;
  assign axi_in_rresp             = rresp_q;
  assign axi_in_rdata             = rdata_q;
  assign axis_write_valid         = wr_valid_q;
  assign axis_write_data          = wr_data_q;
  assign axis_write_dest          = wr_dest_q;
  assign axis_read_request_valid  = req_valid_q;
  assign axis_read_request_data   = req_data_q;
  assign axis_read_response_ready = rsp_ready_q;

endmodule

// File: tb/tb_axil_to_axis.sv
// Scenario bench for axil_to_axis: expected beats/responses are queued when
// stimulus is driven and popped when the DUT presents them.
module tb_axil_to_axis;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = 4'hF;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic [1:0]  bresp, rresp;
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic        wr_valid, wr_ready = 0, rq_valid, rq_ready = 0;
  logic        rs_valid = 0, rs_ready;
  logic [31:0] wr_data, wr_dest, rq_data, rs_data = '0;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] data; logic [31:0] dest; } wbeat_t;
  typedef struct { logic [31:0] data; logic [1:0]  resp; } rbeat_t;
  wbeat_t     wq[$];
  logic [1:0] bq[$];
  rbeat_t     rq[$];

  always #5 clock = ~clock;

  axil_to_axis #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .axi_in_awaddr(awaddr), .axi_in_awvalid(awvalid), .axi_in_awready(awready),
    .axi_in_wdata(wdata), .axi_in_wstrb(wstrb), .axi_in_wvalid(wvalid), .axi_in_wready(wready),
    .axi_in_bresp(bresp), .axi_in_bvalid(bvalid), .axi_in_bready(bready),
    .axi_in_araddr(araddr), .axi_in_arvalid(arvalid), .axi_in_arready(arready),
    .axi_in_rdata(rdata), .axi_in_rresp(rresp), .axi_in_rvalid(rvalid), .axi_in_rready(rready),
    .axis_write_valid(wr_valid), .axis_write_ready(wr_ready),
    .axis_write_data(wr_data), .axis_write_dest(wr_dest),
    .axis_read_request_valid(rq_valid), .axis_read_request_ready(rq_ready),
    .axis_read_request_data(rq_data),
    .axis_read_response_valid(rs_valid), .axis_read_response_ready(rs_ready),
    .axis_read_response_data(rs_data)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    total++;
    if ({awready, wready, arready, bvalid, rvalid, wr_valid, rq_valid, rs_ready} !== 8'b1110_0001) begin
      bad++; $display("FAIL reset_ctrl got %b exp %b",
        {awready, wready, arready, bvalid, rvalid, wr_valid, rq_valid, rs_ready}, 8'b1110_0001);
    end
    total++;
    if ({bresp, rresp, rdata, wr_data, wr_dest, rq_data} !== '0) begin
      bad++; $display("FAIL reset_data got %h/%h/%h/%h/%h/%h exp 0", bresp, rresp, rdata, wr_data, wr_dest, rq_data);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_write_same_cycle();
    wbeat_t e;
    logic [1:0] eb;
    wr_ready = 1; bready = 0;
    awaddr = 32'h43C0_0010; wdata = 32'h1234_5678; awvalid = 1; wvalid = 1;
    wq.push_back('{32'h1234_5678, 32'h43C0_0010}); bq.push_back(2'b00);
    step();
    awvalid = 0; wvalid = 0;
    total++;
    if ({wr_valid, awready, wready} !== 3'b100) begin
      bad++; $display("FAIL w1_beat_valid got %b exp 100", {wr_valid, awready, wready});
    end
    e = wq.pop_front();
    total++;
    if (wr_data !== e.data || wr_dest !== e.dest) begin
      bad++; $display("FAIL w1_beat got %h@%h exp %h@%h", wr_data, wr_dest, e.data, e.dest);
    end
    step();
    eb = bq.pop_front();
    total++;
    if ({wr_valid, bvalid} !== 2'b01 || bresp !== eb) begin
      bad++; $display("FAIL w1_bresp got v=%b b=%b r=%b exp v=0 b=1 r=%b", wr_valid, bvalid, bresp, eb);
    end
    bready = 1;
    step();
    bready = 0;
    total++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      bad++; $display("FAIL w1_done got %b exp 011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_write_split();
    wbeat_t e;
    logic [1:0] eb;
    int beats;
    wr_ready = 0; bready = 0;
    wdata = 32'h0000_A5A5; wvalid = 1;
    step();
    wvalid = 0;
    total++;
    if ({wready, awready, wr_valid} !== 3'b010) begin
      bad++; $display("FAIL w2_have_data got %b exp 010", {wready, awready, wr_valid});
    end
    repeat (2) step();
    awaddr = 32'h20; awvalid = 1;
    wq.push_back('{32'h0000_A5A5, 32'h20}); bq.push_back(2'b00);
    step();
    awvalid = 0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (wr_valid !== 1'b1 || wr_data !== wq[0].data || wr_dest !== wq[0].dest || awready !== 1'b0) begin
        bad++; $display("FAIL w2_hold%0d got v=%b %h@%h exp v=1 %h@%h", i, wr_valid, wr_data, wr_dest, wq[0].data, wq[0].dest);
      end
      step();
    end
    wr_ready = 1;
    beats = 0;
    step();
    e = wq.pop_front();
    beats++;
    eb = bq.pop_front();
    total++;
    if ({wr_valid, bvalid} !== 2'b01 || bresp !== eb) begin
      bad++; $display("FAIL w2_bresp got v=%b b=%b r=%b exp v=0 b=1 r=%b (beat %h)", wr_valid, bvalid, bresp, eb, e.data);
    end
    bready = 1;
    step();
    bready = 0;
    for (int i = 0; i < 3; i++) begin
      if (wr_valid) beats++;
      total++;
      if (bvalid !== 1'b0) begin
        bad++; $display("FAIL w2_extra_b got %b exp 0", bvalid);
      end
      step();
    end
    total++;
    if (beats !== 1) begin
      bad++; $display("FAIL w2_beat_count got %0d exp 1", beats);
    end
  endtask

  task automatic test_read_slow_rready();
    rbeat_t e;
    rready = 0; rq_ready = 1;
    araddr = 32'h44; arvalid = 1;
    step();
    arvalid = 0;
    total++;
    if ({rq_valid, arready, rs_ready} !== 3'b100 || rq_data !== 32'h44) begin
      bad++; $display("FAIL r1_request got %b %h exp 100 00000044", {rq_valid, arready, rs_ready}, rq_data);
    end
    step();
    total++;
    if ({rq_valid, rs_ready} !== 2'b01) begin
      bad++; $display("FAIL r1_wait got %b exp 01", {rq_valid, rs_ready});
    end
    repeat (3) step();
    total++;
    if (rvalid !== 1'b0) begin
      bad++; $display("FAIL r1_early_rvalid got %b exp 0", rvalid);
    end
    rs_valid = 1; rs_data = 32'hCAFE;
    rq.push_back('{32'hCAFE, 2'b00});
    step();
    rs_valid = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rvalid !== 1'b1 || rdata !== rq[0].data || rresp !== rq[0].resp || rs_ready !== 1'b0) begin
        bad++; $display("FAIL r1_hold%0d got v=%b %h r=%b exp v=1 %h r=%b", i, rvalid, rdata, rresp, rq[0].data, rq[0].resp);
      end
      step();
    end
    e = rq.pop_front();
    rready = 1;
    step();
    rready = 0;
    total++;
    if ({rvalid, arready} !== 2'b01) begin
      bad++; $display("FAIL r1_done got %b exp 01 (last %h)", {rvalid, arready}, e.data);
    end
  endtask

  task automatic test_read_timeout();
    rbeat_t e;
    int n;
    rready = 0; rq_ready = 1;
    araddr = 32'h48; arvalid = 1;
    step();
    arvalid = 0;
    step();
    rq.push_back('{32'hDEADBEEF, 2'b10});
    n = 0;
    while (!rvalid && n < 100) begin
      step();
      n++;
    end
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL r2_timeout_cycles got %0d exp 16", n);
    end
    e = rq.pop_front();
    total++;
    if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp) begin
      bad++; $display("FAIL r2_timeout_resp got v=%b %h r=%b exp v=1 %h r=%b", rvalid, rdata, rresp, e.data, e.resp);
    end
    rready = 1;
    step();
    rready = 0;
    total++;
    if (rs_ready !== 1'b1) begin
      bad++; $display("FAIL r2_idle_ready got %b exp 1", rs_ready);
    end
    rs_valid = 1; rs_data = 32'h1111;
    step();
    rs_valid = 0;
    step();
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      bad++; $display("FAIL r2_stale_dropped got v=%b ar=%b exp v=0 ar=1", rvalid, arready);
    end
    araddr = 32'h4C; arvalid = 1;
    step();
    arvalid = 0;
    total++;
    if (rq_data !== 32'h4C) begin
      bad++; $display("FAIL r2_req2_addr got %h exp 0000004c", rq_data);
    end
    step();
    rs_valid = 1; rs_data = 32'h4C4C_0001;
    rq.push_back('{32'h4C4C_0001, 2'b00});
    step();
    rs_valid = 0;
    e = rq.pop_front();
    total++;
    if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp) begin
      bad++; $display("FAIL r2_read2 got v=%b %h r=%b exp v=1 %h r=%b", rvalid, rdata, rresp, e.data, e.resp);
    end
    rready = 1;
    step();
    rready = 0;
  endtask

  task automatic test_concurrent();
    wbeat_t w;
    rbeat_t r;
    logic [1:0] eb;
    wr_ready = 1; rq_ready = 1; bready = 0; rready = 0;
    awaddr = 32'h10; wdata = 32'hBEEF_0010; araddr = 32'h14;
    awvalid = 1; wvalid = 1; arvalid = 1;
    wq.push_back('{32'hBEEF_0010, 32'h10}); bq.push_back(2'b00);
    rq.push_back('{32'h5555_0014, 2'b00});
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    w = wq.pop_front();
    total++;
    if (wr_valid !== 1'b1 || wr_data !== w.data || wr_dest !== w.dest || rq_valid !== 1'b1 || rq_data !== 32'h14) begin
      bad++; $display("FAIL c_beats got w=%b %h@%h r=%b %h exp w=1 %h@%h r=1 00000014",
        wr_valid, wr_data, wr_dest, rq_valid, rq_data, w.data, w.dest);
    end
    step();
    eb = bq.pop_front();
    total++;
    if (bvalid !== 1'b1 || bresp !== eb || rq_valid !== 1'b0) begin
      bad++; $display("FAIL c_b got b=%b r=%b rq=%b exp b=1 r=%b rq=0", bvalid, bresp, rq_valid, eb);
    end
    rs_valid = 1; rs_data = 32'h5555_0014;
    step();
    rs_valid = 0;
    r = rq.pop_front();
    total++;
    if (rvalid !== 1'b1 || rdata !== r.data || rresp !== r.resp || bvalid !== 1'b1) begin
      bad++; $display("FAIL c_r got v=%b %h r=%b b=%b exp v=1 %h r=%b b=1", rvalid, rdata, rresp, bvalid, r.data, r.resp);
    end
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    total++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      bad++; $display("FAIL c_done got %b exp 00111", {bvalid, rvalid, awready, wready, arready});
    end
  endtask

  task automatic test_reset_midflight();
    wbeat_t w;
    wr_ready = 0; rq_ready = 1; bready = 0; rready = 0;
    awaddr = 32'h30; wdata = 32'h77; araddr = 32'h34;
    awvalid = 1; wvalid = 1; arvalid = 1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    step();
    total++;
    if ({wr_valid, rq_valid, rs_ready} !== 3'b101) begin
      bad++; $display("FAIL m_inflight got %b exp 101", {wr_valid, rq_valid, rs_ready});
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({wr_valid, rq_valid, bvalid, rvalid, awready, wready, arready, rs_ready} !== 8'b0000_1111) begin
      bad++; $display("FAIL m_async_reset got %b exp 00001111",
        {wr_valid, rq_valid, bvalid, rvalid, awready, wready, arready, rs_ready});
    end
    step();
    reset = 1'b1;
    step();
    wr_ready = 1;
    awaddr = 32'h38; wdata = 32'h99; awvalid = 1; wvalid = 1;
    wq.push_back('{32'h99, 32'h38}); bq.push_back(2'b00);
    step();
    awvalid = 0; wvalid = 0;
    w = wq.pop_front();
    total++;
    if (wr_valid !== 1'b1 || wr_data !== w.data || wr_dest !== w.dest) begin
      bad++; $display("FAIL m_fresh_beat got v=%b %h@%h exp v=1 %h@%h", wr_valid, wr_data, wr_dest, w.data, w.dest);
    end
    step();
    total++;
    if (bvalid !== 1'b1 || bresp !== bq[0]) begin
      bad++; $display("FAIL m_fresh_b got b=%b r=%b exp b=1 r=%b", bvalid, bresp, bq[0]);
    end
    void'(bq.pop_front());
    bready = 1;
    step();
    bready = 0;
    total++;
    if ({bvalid, wr_valid} !== 2'b00) begin
      bad++; $display("FAIL m_fresh_done got %b exp 00", {bvalid, wr_valid});
    end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_write_split();
    test_read_slow_rready();
    test_read_timeout();
    test_concurrent();
    test_reset_midflight();
    total++;
    if (wq.size() + bq.size() + rq.size() !== 0) begin
      bad++; $display("FAIL scoreboard_empty got %0d exp 0", wq.size() + bq.size() + rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
